// File: rtl/manchester_2_nrz_decoder.sv
// Manchester-to-NRZ receiver: locks on a start bit, decodes mid-bit transitions, assembles MSB-first words.
// Optional MANCH_DEC_GLITCH_FILTER_EN adds a 3-sample majority filter after the input synchronizer.
// Output strobes: bit_valid, word_valid and code_err are single-cycle valid pulses with no ready/backpressure;
// B_out and word_out are qualified by their strobe and hold their value until the next strobe.
module manchester_2_nrz_decoder #(
    parameter int OSR    = 16,
    parameter int WORD_W = 8
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              B_in,
    output logic              B_out,
    output logic              bit_valid,
    output logic [WORD_W-1:0] word_out,
    output logic              word_valid,
    output logic              code_err,
    output logic              locked,
    output logic [1:0]        state_dbg
);

    localparam int CW  = $clog2(2 * OSR);
    localparam int BCW = $clog2(WORD_W);

    localparam logic [CW-1:0]  C_OSR  = CW'(OSR);
    localparam logic [CW-1:0]  C_Q1   = CW'(OSR / 4);
    localparam logic [CW-1:0]  C_Q3   = CW'(3 * OSR / 4);
    localparam logic [CW-1:0]  C_Q5   = CW'(5 * OSR / 4);
    localparam logic [BCW-1:0] C_LAST = BCW'(WORD_W - 1);

    typedef enum logic [1:0] {
        S_HUNT  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic              sync1_q, sync2_q, prev_q;
    logic              sample, edge_w, rise_w, fall_w;
    logic [CW-1:0]     cnt_q, cnt_d, cnt_inc;
    logic              armed_q, armed_d;
    logic [BCW-1:0]    bitcnt_q, bitcnt_d;
    logic [WORD_W-1:0] shift_q, shift_d;
    logic [WORD_W-1:0] word_q, word_d;
    logic              bout_q, bout_d;
    logic              bv_q, bv_d;
    logic              wv_q, wv_d;
    logic              err_q, err_d;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= B_in;
            sync2_q <= sync1_q;
        end
    end

`ifdef MANCH_DEC_GLITCH_FILTER_EN
    logic hist1_q, hist2_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            hist1_q <= 1'b0;
            hist2_q <= 1'b0;
        end else begin
            hist1_q <= sync2_q;
            hist2_q <= hist1_q;
        end
    end

    // Majority over the newest three synchronized samples; the vote is combinational so only one cycle is added.
    assign sample = (sync2_q & hist1_q) | (sync2_q & hist2_q) | (hist1_q & hist2_q);
`else
    assign sample = sync2_q;
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset) prev_q <= 1'b0;
        else       prev_q <= sample;
    end

    assign edge_w = sample ^ prev_q;
    assign rise_w = edge_w & sample;
    assign fall_w = edge_w & ~sample;

    // cnt_inc is the number of samples since the last accepted edge, including the current one.
    assign cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= S_HUNT;
            cnt_q    <= '0;
            armed_q  <= 1'b0;
            bitcnt_q <= '0;
            shift_q  <= '0;
            word_q   <= '0;
            bout_q   <= 1'b0;
            bv_q     <= 1'b0;
            wv_q     <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            armed_q  <= armed_d;
            bitcnt_q <= bitcnt_d;
            shift_q  <= shift_d;
            word_q   <= word_d;
            bout_q   <= bout_d;
            bv_q     <= bv_d;
            wv_q     <= wv_d;
            err_q    <= err_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_inc;
        armed_d  = armed_q;
        bitcnt_d = bitcnt_q;
        shift_d  = shift_q;
        word_d   = word_q;
        bout_d   = bout_q;
        bv_d     = 1'b0;
        wv_d     = 1'b0;
        err_d    = 1'b0;
        case (state_q)
            S_HUNT: begin
                if (sample) begin
                    cnt_d   = '0;
                    armed_d = 1'b0;
                    if (rise_w && armed_q) state_d = S_START;
                end else if (cnt_inc >= C_OSR) begin
                    armed_d = 1'b1;
                end
            end
            S_START: begin
                if (edge_w) begin
                    cnt_d = '0;
                    if (fall_w && cnt_inc >= C_Q1 && cnt_inc <= C_Q3) begin
                        state_d  = S_DATA;
                        bitcnt_d = '0;
                    end else begin
                        state_d = S_HUNT;
                        err_d   = 1'b1;
                    end
                end else if (cnt_inc > C_Q3) begin
                    state_d = S_HUNT;
                    cnt_d   = '0;
                    err_d   = 1'b1;
                end
            end
            S_DATA: begin
                // Edges before the 3/4-bit point are bit-boundary edges and leave the counter running.
                if (edge_w && cnt_inc >= C_Q3 && cnt_inc <= C_Q5) begin
                    cnt_d   = '0;
                    bout_d  = fall_w;
                    bv_d    = 1'b1;
                    shift_d = {shift_q[WORD_W-2:0], fall_w};
                    if (bitcnt_q == C_LAST) begin
                        word_d   = {shift_q[WORD_W-2:0], fall_w};
                        wv_d     = 1'b1;
                        bitcnt_d = '0;
                    end else begin
                        bitcnt_d = bitcnt_q + 1'b1;
                    end
                end else if (cnt_inc > C_Q5) begin
                    state_d  = S_HUNT;
                    cnt_d    = '0;
                    err_d    = (bitcnt_q != '0);
                    bitcnt_d = '0;
                end
            end
            default: begin
                state_d = S_HUNT;
                cnt_d   = '0;
                armed_d = 1'b0;
            end
        endcase
    end

    always_comb begin
        B_out      = bout_q;
        bit_valid  = bv_q;
        word_out   = word_q;
        word_valid = wv_q;
        code_err   = err_q;
        locked     = (state_q == S_DATA);
        state_dbg  = state_q;
    end

endmodule

// File: tb/tb_manchester_2_nrz_decoder.sv
// Self-checking bench for manchester_2_nrz_decoder: table of frames plus hand-written reset,
// coding-error and glitch sequences, checked against a queue-based scoreboard.
module tb_manchester_2_nrz_decoder;

  localparam int OSR = 16;
  localparam int W   = 8;

  logic         clock;
  logic         reset;
  logic         B_in;
  logic         B_out;
  logic         bit_valid;
  logic [W-1:0] word_out;
  logic         word_valid;
  logic         code_err;
  logic         locked;
  logic [1:0]   state_dbg;

  manchester_2_nrz_decoder #(.OSR(OSR), .WORD_W(W)) dut (
    .clock      (clock),
    .reset      (reset),
    .B_in       (B_in),
    .B_out      (B_out),
    .bit_valid  (bit_valid),
    .word_out   (word_out),
    .word_valid (word_valid),
    .code_err   (code_err),
    .locked     (locked),
    .state_dbg  (state_dbg)
  );

  // clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish, time=%0t required finish", $time);
    $fatal(1, "watchdog");
  end

  // scoreboard state
  logic         bit_q[$];
  logic [W-1:0] exp_q[$];
  int           err_q[$];
  int           n_checks = 0;
  int           n_fail   = 0;
  int           words_rx = 0;
  int           last_bv  = 0;
  logic         lock_chk = 1'b1;
  logic         locked_prev = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // driver tasks
  task automatic drive(input logic v, input int n);
    B_in = v;
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic send_frame(input logic [15:0] data, input int nbits, input int mode, input int gap);
    logic [W-1:0] acc;
    int           k;
    int           h1;
    logic         b;
    acc = '0;
    k   = 0;
    drive(1'b1, OSR / 2);
    drive(1'b0, OSR / 2);
    for (int i = 0; i < nbits; i++) begin
      b  = data[nbits-1-i];
      h1 = OSR / 2;
      if (mode == 1) h1 = (i % 2 == 0) ? OSR / 2 - 1 : OSR / 2 + 1;
      bit_q.push_back(b);
      acc = {acc[W-2:0], b};
      k++;
      if (k == W) begin
        exp_q.push_back(acc);
        k = 0;
      end
      drive(b, h1);
      drive(~b, OSR / 2);
    end
    if (gap > 0) drive(1'b0, gap);
  endtask

  // output monitor
  always @(negedge clock) begin
    if (!reset) begin
      if (bit_valid) begin
        check("bit_expected", (bit_q.size() != 0), 1);
        if (bit_q.size() != 0) check("bit_value", B_out, bit_q.pop_front());
        last_bv = cyc;
      end
      if (word_valid) begin
        check("word_with_bit", bit_valid, 1);
        check("word_expected", (exp_q.size() != 0), 1);
        if (exp_q.size() != 0) check("word_value", word_out, exp_q.pop_front());
        words_rx++;
      end
      if (code_err) begin
        int d;
        check("err_not_with_bit", bit_valid, 0);
        check("err_expected", (err_q.size() != 0), 1);
        if (err_q.size() != 0) begin
          d = err_q.pop_front();
          if (d >= 0) check("err_delay", cyc - last_bv, d);
        end
      end
      if (lock_chk && locked_prev && !locked) check("lock_fall_delay", cyc - last_bv, 21);
    end
    locked_prev = locked;
  end

  typedef struct {
    logic [15:0] data;
    int          nbits;
    int          mode;
    int          exp_words;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int w0;

    vecs[0] = '{data: 16'h00A5, nbits: 8,  mode: 0, exp_words: 1};
    vecs[1] = '{data: 16'h00FF, nbits: 16, mode: 0, exp_words: 2};
    vecs[2] = '{data: 16'h003C, nbits: 8,  mode: 1, exp_words: 1};
    vecs[3] = '{data: 16'($urandom_range(0, 255)), nbits: 8, mode: 0, exp_words: 1};
    vecs[4] = '{data: 16'($urandom_range(0, 65535)), nbits: 16, mode: 1, exp_words: 2};
    vecs[5] = '{data: 16'($urandom_range(0, 255)), nbits: 8, mode: 1, exp_words: 1};

    reset = 1'b1;
    B_in  = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    check("rst_B_out", B_out, 0);
    check("rst_bit_valid", bit_valid, 0);
    check("rst_word_out", word_out, 0);
    check("rst_word_valid", word_valid, 0);
    check("rst_code_err", code_err, 0);
    check("rst_locked", locked, 0);
    check("rst_state", state_dbg, 0);
    reset = 1'b0;
    drive(1'b0, 24);

    // reset in the middle of a frame, then a clean 0x5A frame
    send_frame(16'h0006, 3, 0, 0);
    drive(1'b1, 2);
    lock_chk = 1'b0;
    reset = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    check("midrst_B_out", B_out, 0);
    check("midrst_bit_valid", bit_valid, 0);
    check("midrst_word_out", word_out, 0);
    check("midrst_word_valid", word_valid, 0);
    check("midrst_code_err", code_err, 0);
    check("midrst_locked", locked, 0);
    check("midrst_state", state_dbg, 0);
    B_in = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
    drive(1'b0, 24);
    lock_chk = 1'b1;
    w0 = words_rx;
    send_frame(16'h005A, 8, 0, 48);
    check("post_rst_words", words_rx - w0, 1);
    check("post_rst_word_out", word_out, 8'h5A);

    // table-driven frames
    for (int i = 0; i < 6; i++) begin
      w0 = words_rx;
      send_frame(vecs[i].data, vecs[i].nbits, vecs[i].mode, 48);
      check("vec_words", words_rx - w0, vecs[i].exp_words);
      check("vec_locked_idle", locked, 0);
      check("vec_state_idle", state_dbg, 0);
    end

    // line stuck after three data bits: partial word dropped, error 21 cycles after last bit
    w0 = words_rx;
    err_q.push_back(21);
    send_frame(16'h0005, 3, 0, 0);
    drive(1'b0, 2 * OSR);
    drive(1'b0, 48);
    check("stuck_no_word", words_rx - w0, 0);
    check("stuck_locked", locked, 0);
    check("stuck_state", state_dbg, 0);

    // single-sample glitch on an armed idle line
`ifndef MANCH_DEC_GLITCH_FILTER_EN
    err_q.push_back(-1);
`endif
    drive(1'b1, 1);
    drive(1'b0, 8);
    check("glitch_state", state_dbg, 0);
    check("glitch_locked", locked, 0);
    drive(1'b0, 40);
    w0 = words_rx;
    send_frame(16'h0081, 8, 0, 48);
    check("glitch_recover_words", words_rx - w0, 1);

    check("bit_q_drained", bit_q.size(), 0);
    check("word_q_drained", exp_q.size(), 0);
    check("err_q_drained", err_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/manchester_2_nrz_decoder.md
# manchester_2_nrz_decoder

Receive-side counterpart of the NRZ-to-Manchester encoder: recovers NRZ data from a Manchester-coded serial line sampled by an oversampling clock. Locks on a start bit, tracks mid-bit transitions, emits each decoded bit with a strobe and assembles WORD_W-bit words MSB first. Flags coding errors and returns to hunt on frame end or error. Sits between the line input pin and the word-level receive logic.

## Interface
- OSR, 16, samples (clock cycles) per bit; multiple of 4, ≥ 8
- WORD_W, 8, bits per assembled word; ≥ 2
- clock  input  1  sample clock, rising edge
- reset  input  1  asynchronous, active-high
- B_in  input  1  Manchester line; asynchronous to clock; idle low
- B_out  output  1  last decoded NRZ bit, held until next bit
- bit_valid  output  1  one-cycle strobe, B_out updated this cycle
- word_out  output  WORD_W  last complete word, MSB = first received bit
- word_valid  output  1  one-cycle strobe, word_out updated this cycle
- code_err  output  1  one-cycle strobe on any coding/framing error
- locked  output  1  high while in DATA state

## Operation
- Code: bit value in first half-period, complement in second. Mid-bit falling edge = 1, rising = 0. Boundary edges carry no data.
- B_in passes a 2-flop synchronizer; edge = synchronized sample differs from previous synchronized sample.
- Sample counter cnt, width ⌈log2(2·OSR)⌉, increments every cycle, cleared on each accepted edge.
- HUNT: require ≥ OSR consecutive low samples to arm; armed rising edge → START, cnt=0. Falling edges ignored.
- START (start bit, value 1, not output): edge with cnt < OSR/4 → code_err, HUNT. Falling edge with OSR/4 ≤ cnt ≤ 3·OSR/4 → DATA, cnt=0, bit count=0. Rising edge in window, or cnt > 3·OSR/4 → code_err, HUNT.
- DATA: edges with cnt < 3·OSR/4 ignored (boundary edges). First edge with 3·OSR/4 ≤ cnt ≤ 5·OSR/4 is mid-bit: B_out = (falling), bit_valid pulse, shift into word register, cnt=0. On WORD_W-th bit: word_out = assembled word, word_valid pulse coincident with that bit_valid, bit count=0.
- DATA timeout (cnt > 5·OSR/4, no edge): frame end → HUNT. If bit count ≠ 0, code_err pulse, partial word discarded; else no pulse.
- code_err never coincides with bit_valid. word_out unchanged on error.

## Timing
- Reset: state HUNT, not armed, cnt=0, synchronizer flops 0, B_out=0, bit_valid=0, word_out=0, word_valid=0, code_err=0, locked=0.
- Reset mid-frame: immediate return to reset values; partial word discarded, no strobes.
- Latency: bit_valid asserts on the 3rd rising clock edge after the edge that first samples the new B_in level (4th with filter).
- locked rises with the cycle entering DATA; falls the cycle after timeout or error.
- Drift tolerance: ±OSR/4 samples per bit relative to previous mid-bit edge.
- Back-to-back frames need ≥ 5·OSR/4 + OSR idle-low samples between them.

## Configuration
- MANCH_DEC_GLITCH_FILTER_EN defined: 3-sample majority filter after synchronizer; single-sample glitches removed; latency +1 cycle.
- Undefined: no filter; raw synchronized samples used; latency as above.

## Test plan
- Reset asserted mid-stream, all outputs checked → all outputs 0, locked=0; next frame 0x5A decoded correctly after release.
- OSR=16, WORD_W=8, start bit + 0xA5 clean → eight bit_valid with B_out 1,0,1,0,0,1,0,1; one word_valid, word_out=0xA5; code_err=0; locked falls 21 cycles after last mid-bit edge (HUNT entry).
- Back-to-back 16-bit frame 0x00,0xFF → word_valid twice, word_out 0x00 then 0xFF, no code_err.
- Bit periods alternating 15/17 samples, byte 0x3C → word_out=0x3C, no code_err.
- Line held constant 2 bit periods after 3 data bits → code_err one pulse 21 cycles after 3rd mid-bit edge, no word_valid, locked=0.
- Single-sample high glitch on idle-low armed line → with MANCH_DEC_GLITCH_FILTER_EN: no state change, code_err=0; without: code_err pulse, back in HUNT.
